aes_inv_shift_sub_serial: RTL and testbench

//  Decryption-path InvShiftRows + InvSubBytes stage. Accepts one 128-bit AES state.

---
 rtl/aes_pkg.sv | 67 ++++++
 rtl/inv_sub_bytes.sv | 11 +
 rtl/aes_inv_shift_sub_serial.sv | 120 ++++++++++++
 tb/tb_aes_inv_shift_sub_serial.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the decryption datapath: widths, byte indexing,
// InvShiftRows, GF(2^8) arithmetic and the serial stage FSM encoding.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTE_W  = 8;
    localparam int AES_NB      = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_t;

    function automatic int byte_row(input int i);
        return i % 4;
    endfunction

    function automatic int byte_col(input int i);
        return i / 4;
    endfunction

    function automatic int byte_idx(input int r, input int c);
        return r + 4 * c;
    endfunction

    // Byte 0 sits in the most significant lane of the 128-bit state.
    function automatic int byte_lsb(input int i);
        return (AES_NB - 1 - i) * AES_BYTE_W;
    endfunction

    function automatic logic [AES_STATE_W-1:0] inv_shift_rows(input logic [AES_STATE_W-1:0] s);
        logic [AES_STATE_W-1:0] res;
        res = '0;
        for (int i = 0; i < AES_NB; i++) begin
            res[byte_lsb(i) +: AES_BYTE_W] =
                s[byte_lsb(byte_idx(byte_row(i), (byte_col(i) - byte_row(i) + 4) % 4)) +: AES_BYTE_W];
        end
        return res;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse affine map, then multiplicative inverse as x^254 (0 maps to 0).
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

endpackage

// File: rtl/inv_sub_bytes.sv
// Combinational AES inverse S-box for a single byte.
module inv_sub_bytes
    import aes_pkg::*;
(
    input  logic [7:0] state_byte,
    output logic [7:0] subst_byte
);

    assign subst_byte = inv_sbox(state_byte);

endmodule

// File: rtl/aes_inv_shift_sub_serial.sv
// InvShiftRows at capture, then InvSubBytes streamed BPC bytes per cycle
// through a bank of inverse S-boxes; result held until the consumer accepts it.
module aes_inv_shift_sub_serial
    import aes_pkg::*;
#(
    parameter int BPC = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_data,
    output logic                   busy
);

    localparam int N  = AES_NB / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8 || BPC == 16)) begin : g_bad_bpc
            $error("aes_inv_shift_sub_serial: BPC must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    fsm_state_t             state_r;
    fsm_state_t             state_nxt_s;
    logic [CW-1:0]          counter_r;
    logic [AES_STATE_W-1:0] shift_r;
    logic [AES_STATE_W-1:0] result_r;
    logic                   in_ready_r;
    logic                   out_valid_r;
    logic                   busy_r;
    logic                   accept_s;
    logic                   release_s;
    logic                   last_s;
    logic [3:0]             lane_idx_s [BPC];
    logic [7:0]             lane_in_s  [BPC];
    logic [7:0]             lane_out_s [BPC];

    // Lane mux: select the current BPC-byte slice of the shifted state.
    always_comb begin
        for (int j = 0; j < BPC; j++) begin
            lane_idx_s[j] = 4'(int'(counter_r) * BPC + j);
            lane_in_s[j]  = shift_r[byte_lsb(int'(lane_idx_s[j])) +: AES_BYTE_W];
        end
    end

    for (genvar g = 0; g < BPC; g++) begin : g_lane
        inv_sub_bytes u_sbox (
            .state_byte (lane_in_s[g]),
            .subst_byte (lane_out_s[g])
        );
    end

    assign accept_s  = in_ready_r & in_valid;
    assign release_s = out_valid_r & out_ready;
    assign last_s    = (counter_r == CW'(N - 1));

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = ST_BUSY;
                else          state_nxt_s = ST_IDLE;
            end
            ST_BUSY: begin
                if (last_s) state_nxt_s = ST_DONE;
                else        state_nxt_s = ST_BUSY;
            end
            ST_DONE: begin
                if (release_s) state_nxt_s = ST_IDLE;
                else           state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State and handshake flags, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_IDLE);
            out_valid_r <= (state_nxt_s == ST_DONE);
            busy_r      <= (state_nxt_s == ST_BUSY) || (state_nxt_s == ST_DONE);
        end
    end

    // Datapath: capture shifted state, then fill result lanes slice by slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_r <= '0;
            shift_r   <= '0;
            result_r  <= '0;
        end else if (accept_s) begin
            counter_r <= '0;
            shift_r   <= inv_shift_rows(in_data);
            result_r  <= '0;
        end else if (state_r == ST_BUSY) begin
            for (int j = 0; j < BPC; j++) begin
                result_r[byte_lsb(int'(lane_idx_s[j])) +: AES_BYTE_W] <= lane_out_s[j];
            end
            counter_r <= last_s ? '0 : counter_r + CW'(1);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_data  = out_valid_r ? result_r : '0;

endmodule

// File: tb/tb_aes_inv_shift_sub_serial.sv
// Randomized self-checking bench: five instances (BPC 1..16) against a
// table-driven AES inverse S-box / InvShiftRows reference model.
module tb_aes_inv_shift_sub_serial;

    localparam logic [127:0] VEC1_IN  = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [127:0] VEC1_OUT = 128'hbd6e7c3df2b5779e0b61216e8b10b689;

    logic         clk;
    logic         rst_n;
    logic         in_valid_a  [5];
    logic         in_ready_a  [5];
    logic [127:0] in_data_a   [5];
    logic         out_valid_a [5];
    logic         out_ready_a [5];
    logic [127:0] out_data_a  [5];
    logic         busy_a      [5];

    int           n_tests;
    int           n_fail;
    logic [7:0]   inv_tab [256];

    for (genvar g = 0; g < 5; g++) begin : g_dut
        aes_inv_shift_sub_serial #(.BPC(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_a[g]),
            .in_ready  (in_ready_a[g]),
            .in_data   (in_data_a[g]),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready_a[g]),
            .out_data  (out_data_a[g]),
            .busy      (busy_a[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        while (y != 8'h00) begin
            if (y[0]) p = p ^ x;
            y = y >> 1;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] w;
        w = {b, b} << n;
        return w[15:8];
    endfunction

    // Forward S-box by brute-force inversion + affine map, then invert the table.
    task automatic build_table();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (tb_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            inv_tab[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] ref_model(input logic [127:0] s);
        logic [127:0] res;
        int src;
        res = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                src = r + 4 * ((c - r + 4) % 4);
                res[127 - 8 * (r + 4 * c) -: 8] = inv_tab[s[127 - 8 * src -: 8]];
            end
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_ready(input int d, output bit ok);
        int n = 0;
        while (!in_ready_a[d] && n < 30) begin
            @(posedge clk); #1; n++;
        end
        ok = in_ready_a[d];
        if (!ok) check("ready_timeout", 128'(in_ready_a[d]), 128'(1));
    endtask

    task automatic run_txn(input int d, input logic [127:0] data, input logic [127:0] exp, input int hold);
        int lat;
        bit ok, rdy;
        wait_ready(d, rdy);
        if (!rdy) return;
        in_valid_a[d]  = 1'b1;
        in_data_a[d]   = data;
        out_ready_a[d] = (hold == 0);
        @(posedge clk); #1;
        in_valid_a[d] = 1'b0;
        in_data_a[d]  = rand128();
        ok  = !in_ready_a[d] && busy_a[d];
        lat = 0;
        do begin
            if (!out_valid_a[d] && (in_ready_a[d] || !busy_a[d])) ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end while (!out_valid_a[d] && lat < 40);
        check("latency", 128'(lat), 128'(16 >> d));
        check("busy_no_ready", 128'(ok), 128'(1));
        check("out_data", out_data_a[d], exp);
        if (hold > 0) begin
            ok = 1'b1;
            for (int h = 0; h < hold; h++) begin
                in_valid_a[d] = (h == 1);
                @(posedge clk); #1;
                if (!out_valid_a[d] || in_ready_a[d] || out_data_a[d] !== exp) ok = 1'b0;
            end
            in_valid_a[d] = 1'b0;
            check("hold_stable", 128'(ok), 128'(1));
            out_ready_a[d] = 1'b1;
        end
        @(posedge clk); #1;
        check("post_handshake", {in_ready_a[d], out_valid_a[d], busy_a[d], |out_data_a[d]}, 128'(4'b1000));
        out_ready_a[d] = 1'b0;
    endtask

    task automatic back_to_back(input int d);
        logic [127:0] q[$];
        int acc_t[$];
        logic [127:0] od, exp;
        bit acc, hs;
        int cyc = 0, sent = 0, got = 0;
        out_ready_a[d] = 1'b1;
        in_valid_a[d]  = 1'b1;
        in_data_a[d]   = rand128();
        while (got < 3 && cyc < 200) begin
            acc = in_valid_a[d] && in_ready_a[d];
            hs  = out_valid_a[d] && out_ready_a[d];
            od  = out_data_a[d];
            @(posedge clk); #1;
            cyc++;
            if (hs) begin
                got++;
                if (q.size() == 0) check("b2b_extra_output", 128'(1), 128'(0));
                else begin
                    exp = q.pop_front();
                    check("b2b_data", od, exp);
                end
            end
            if (acc) begin
                q.push_back(ref_model(in_data_a[d]));
                acc_t.push_back(cyc);
                sent++;
                if (sent == 3) in_valid_a[d] = 1'b0;
                else           in_data_a[d] = rand128();
            end
        end
        in_valid_a[d]  = 1'b0;
        out_ready_a[d] = 1'b0;
        check("b2b_outputs", 128'(got), 128'(3));
        check("b2b_accepts", 128'(acc_t.size()), 128'(3));
        if (acc_t.size() == 3) begin
            check("b2b_period0", 128'(acc_t[1] - acc_t[0]), 128'((16 >> d) + 2));
            check("b2b_period1", 128'(acc_t[2] - acc_t[1]), 128'((16 >> d) + 2));
        end
    endtask

    initial begin
        bit rdy;
        logic [127:0] ramp, v;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        for (int d = 0; d < 5; d++) begin
            in_valid_a[d] = 1'b0; in_data_a[d] = '0; out_ready_a[d] = 1'b0;
        end
        build_table();
        #3;
        for (int d = 0; d < 5; d++)
            check("reset_state", {in_ready_a[d], out_valid_a[d], busy_a[d], |out_data_a[d]}, 128'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // FIPS-197 vector across every BPC, with latency checks
        for (int d = 0; d < 5; d++) run_txn(d, VEC1_IN, VEC1_OUT, 0);

        // Uniform and ramp patterns
        run_txn(2, '0, {16{8'h52}}, 0);
        run_txn(2, {16{8'h63}}, '0, 0);
        for (int i = 0; i < 16; i++) ramp[127 - 8 * i -: 8] = 8'(i);
        run_txn(2, ramp, ref_model(ramp), 0);

        // Backpressure with a stray in_valid pulse in DONE
        run_txn(2, VEC1_IN, VEC1_OUT, 5);

        // Reset in the middle of BUSY (BPC=1, counter 7)
        wait_ready(0, rdy);
        in_valid_a[0] = 1'b1;
        in_data_a[0]  = VEC1_IN;
        @(posedge clk); #1;
        in_valid_a[0] = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("reset_mid_busy", {in_ready_a[0], out_valid_a[0], busy_a[0], |out_data_a[0]}, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(0, VEC1_IN, VEC1_OUT, 0);

        // Back-to-back streaming
        back_to_back(2);
        back_to_back(4);

        // Random states on every instance with random backpressure
        for (int d = 0; d < 5; d++)
            for (int k = 0; k < 3; k++) begin
                v = rand128();
                run_txn(d, v, ref_model(v), $urandom_range(0, 3));
            end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
